frame_capture_ctrl: RTL
=======================

Name: frame_capture_ctrl

Overview:
- Sequences one camera frame out of the frame buffer into the pixel-transfer block.
- The CPU configures the window and starts a capture over an Avalon-MM slave.
- The block then freezes the frame buffer and fetches pixels through a read master, presenting them one at a time on a pix_rdy/get_next_pix handshake.
- It signals img_done after the last pixel is consumed. It sits between the D8M frame buffer and the HPS pixel-transfer slave.

Parameters:
- ADDR_W, 19, frame-buffer word-address width.
- DIM_W, 10, width/height register width (max 1023).
- CNT_W, 20, pixel-counter width; must hold 2*DIM_W product bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- address  in  3  CPU slave word address
- read  in  1  CPU read strobe
- readdata  out  32  CPU read data, combinational from registers
- write  in  1  CPU write strobe
- writedata  in  32  CPU write data
- waitrequest  out  1  tied 0
- frame_valid  in  1  frame buffer holds a complete frame
- fb_freeze  out  1  inhibits camera writes to the frame buffer
- fb_addr  out  ADDR_W  frame-buffer read address
- fb_read  out  1  read request
- fb_waitrequest  in  1  read stall
- fb_readdata  in  24  RGB pixel
- fb_readdatavalid  in  1  read data valid, variable latency ≥1
- pix_rdy  out  1  pixel_data valid, level signal
- pixel_data  out  24  current pixel
- img_done  out  1  frame complete
- get_next_pix  in  1  consumer took the current pixel

Behaviour:
- Reset: all outputs 0, state IDLE; registers WIDTH=0, HEIGHT=0, BASE=0, STATUS=0, count=0.
- Registers:
  - 0 CTRL (WO): bit0 start, bit1 abort, both self-clearing.
  - 1 STATUS (RO): bit0 busy, bit1 done, bit2 cfg_err, bit3 aborted.
  - 2 WIDTH (RW).
  - 3 HEIGHT (RW).
  - 4 BASE (RW, ADDR_W bits).
  - 5 COUNT (RO, pixels delivered).
- Unmapped reads return 0; unmapped writes are ignored.
- WIDTH/HEIGHT/BASE writes while busy are ignored.
- total = WIDTH*HEIGHT, computed at start and held for the capture.
- FSM states:
  - IDLE: on start, if WIDTH==0 or HEIGHT==0, set cfg_err and stay in IDLE. Otherwise clear done/cfg_err/aborted, clear count and img_done, set busy, go to WAIT_FRAME.
  - WAIT_FRAME: when frame_valid=1, set fb_freeze=1 and go to FETCH.
  - FETCH: fb_read=1, fb_addr=BASE+count (truncated to ADDR_W, wraps). Hold until fb_waitrequest=0 in the same cycle, then go to WAIT_DATA.
  - WAIT_DATA: on fb_readdatavalid, latch pixel_data, set pix_rdy=1, go to PRESENT.
  - PRESENT: hold pix_rdy and pixel_data. On get_next_pix: pix_rdy←0, count←count+1. If count+1==total go to FINISH, else go to FETCH.
  - FINISH (one cycle): img_done←1, fb_freeze←0, busy←0, done←1, go to IDLE. img_done stays 1 until the next accepted start or an abort.
- Handshake rules:
  - get_next_pix is ignored unless in PRESENT.
  - Exactly one fb read is outstanding.
  - Fetch-to-present latency is 2 cycles plus the fb wait and read latency.
  - The CPU sees the first pixel no earlier than 3 cycles after frame_valid.
- Abort in any non-IDLE state has priority over every other event in that cycle:
  - pix_rdy, fb_read, fb_freeze, img_done, busy all ←0; aborted←1; go to IDLE.
  - Any fb_readdatavalid arriving later in IDLE is dropped.
- Start while busy is ignored. Start together with abort in the same write: abort wins and start is ignored.
- Async rst mid-capture returns everything to reset values immediately.

Test Plan:
- W=2, H=2, BASE=0x100, frame_valid=1, fb latency 1, get_next_pix pulsed 3 cycles after each pix_rdy → fb_addr sequence 0x100..0x103; 4 pixels delivered in order; img_done=1 after the 4th pulse; STATUS=0x2; COUNT=4; fb_freeze low at the end.
- fb_waitrequest high for 5 cycles and readdatavalid latency 4 → fb_read held stable through the stall; pix_rdy rises only after valid; pixel value correct.
- Start with HEIGHT=0 → STATUS=0x4; no fb_read; busy never set.
- Abort written while in PRESENT on the 3rd of 6 pixels → next cycle pix_rdy=0, fb_freeze=0, STATUS=0x8, COUNT=2. A late readdatavalid is ignored.
- get_next_pix pulses in WAIT_FRAME and FETCH → no count change. Start while busy → no restart. Second start after done → img_done clears and count restarts at 0.
- BASE=2^19-2, W=4, H=1 → fb_addr wraps to 0 and 1. Async rst asserted mid-FETCH → all outputs 0 without waiting for a clock edge.

Source files
------------

// File: rtl/frame_capture_ctrl_if.sv
// Bundles the CPU slave, frame-buffer read master and pixel handshake of the frame capture block.
// The slave modport is the capture controller side; master is the CPU/frame-buffer/consumer side.
interface frame_capture_ctrl_if #(
    parameter int ADDR_W = 19
);
    logic [2:0]        address;
    logic              read;
    logic [31:0]       readdata;
    logic              write;
    logic [31:0]       writedata;
    logic              waitrequest;
    logic              frame_valid;
    logic              fb_freeze;
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_read;
    logic              fb_waitrequest;
    logic [23:0]       fb_readdata;
    logic              fb_readdatavalid;
    logic              pix_rdy;
    logic [23:0]       pixel_data;
    logic              img_done;
    logic              get_next_pix;

    modport slave (
        input  address, read, write, writedata, frame_valid,
               fb_waitrequest, fb_readdata, fb_readdatavalid, get_next_pix,
        output readdata, waitrequest, fb_freeze, fb_addr, fb_read,
               pix_rdy, pixel_data, img_done
    );

    modport master (
        output address, read, write, writedata, frame_valid,
               fb_waitrequest, fb_readdata, fb_readdatavalid, get_next_pix,
        input  readdata, waitrequest, fb_freeze, fb_addr, fb_read,
               pix_rdy, pixel_data, img_done
    );
endinterface

// File: rtl/frame_capture_ctrl.sv
// Streams one frozen frame from the frame buffer to the pixel consumer, one outstanding read at a time.
// Fetch-to-present is 2 cycles plus fb stall and read latency; pixels hold until get_next_pix.
module frame_capture_ctrl #(
    parameter int ADDR_W = 19,
    parameter int DIM_W  = 10,
    parameter int CNT_W  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    frame_capture_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        FETCH,
        WAIT_DATA,
        PRESENT,
        FINISH
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [DIM_W-1:0]  width;
    logic [DIM_W-1:0]  height;
    logic [ADDR_W-1:0] base;
    logic              busy;
    logic              done;
    logic              cfg_err;
    logic              aborted;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  total;
    logic [CNT_W-1:0]  count_inc;

    logic              pix_rdy;
    logic [23:0]       pixel_data;
    logic              fb_freeze;
    logic              img_done;
    logic [31:0]       rdata;

    logic              ctrl_wr;
    logic              abort_req;
    logic              start_req;
    logic              cfg_ok;
    logic              unused_bits;

    assign ctrl_wr   = bus.write && (bus.address == 3'd0);
    assign abort_req = ctrl_wr && bus.writedata[1];
    // Abort in the same write suppresses start, even when idle.
    assign start_req = ctrl_wr && bus.writedata[0] && !bus.writedata[1];
    assign cfg_ok    = (width != '0) && (height != '0);
    assign count_inc = count + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (start_req && cfg_ok) state_nxt = WAIT_FRAME;
            WAIT_FRAME: if (bus.frame_valid) state_nxt = FETCH;
            FETCH:      if (!bus.fb_waitrequest) state_nxt = WAIT_DATA;
            WAIT_DATA:  if (bus.fb_readdatavalid) state_nxt = PRESENT;
            PRESENT:    if (bus.get_next_pix) state_nxt = (count_inc == total) ? FINISH : FETCH;
            FINISH:     state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
        if (abort_req && (state != IDLE)) begin
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width      <= '0;
            height     <= '0;
            base       <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_err    <= 1'b0;
            aborted    <= 1'b0;
            count      <= '0;
            total      <= '0;
            pix_rdy    <= 1'b0;
            pixel_data <= '0;
            fb_freeze  <= 1'b0;
            img_done   <= 1'b0;
        end else begin
            if (bus.write && !busy) begin
                case (bus.address)
                    3'd2:    width  <= bus.writedata[DIM_W-1:0];
                    3'd3:    height <= bus.writedata[DIM_W-1:0];
                    3'd4:    base   <= bus.writedata[ADDR_W-1:0];
                    default: ;
                endcase
            end

            if (abort_req && (state != IDLE)) begin
                pix_rdy   <= 1'b0;
                fb_freeze <= 1'b0;
                img_done  <= 1'b0;
                busy      <= 1'b0;
                aborted   <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_req) begin
                            if (!cfg_ok) begin
                                cfg_err <= 1'b1;
                            end else begin
                                done     <= 1'b0;
                                cfg_err  <= 1'b0;
                                aborted  <= 1'b0;
                                count    <= '0;
                                img_done <= 1'b0;
                                busy     <= 1'b1;
                                total    <= CNT_W'(width) * CNT_W'(height);
                            end
                        end
                    end
                    WAIT_FRAME: begin
                        if (bus.frame_valid) fb_freeze <= 1'b1;
                    end
                    WAIT_DATA: begin
                        if (bus.fb_readdatavalid) begin
                            pixel_data <= bus.fb_readdata;
                            pix_rdy    <= 1'b1;
                        end
                    end
                    PRESENT: begin
                        if (bus.get_next_pix) begin
                            pix_rdy <= 1'b0;
                            count   <= count_inc;
                        end
                    end
                    FINISH: begin
                        img_done  <= 1'b1;
                        fb_freeze <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = '0;
        case (bus.address)
            3'd1:    rdata = {28'd0, aborted, cfg_err, done, busy};
            3'd2:    rdata = 32'(width);
            3'd3:    rdata = 32'(height);
            3'd4:    rdata = 32'(base);
            3'd5:    rdata = 32'(count);
            default: rdata = '0;
        endcase
    end

    // Address is only driven while a read is being requested so idle outputs stay quiet.
    assign bus.fb_addr     = (state == FETCH) ? (base + ADDR_W'(count)) : '0;
    assign bus.fb_read     = (state == FETCH);
    assign bus.readdata    = rdata;
    assign bus.waitrequest = 1'b0;
    assign bus.fb_freeze   = fb_freeze;
    assign bus.pix_rdy     = pix_rdy;
    assign bus.pixel_data  = pixel_data;
    assign bus.img_done    = img_done;

    assign unused_bits = ^{bus.read, bus.writedata[31:ADDR_W]};

endmodule
